ds_fwd_interlock: RTL and testbench
===================================

Name: ds_fwd_interlock

Overview:
Parametrised operand-forwarding and interlock unit for the decode stage, generalising the single-source load-use check to NSRC bypass sources and NRD register read ports.
- Per source, selects the youngest matching forwarded value over the register-file read data.
- Stalls decode when a matching producer's data is not yet available.
- Tracks an outstanding mult/div with a latency down-counter, so mfhi/mflo interlock on HI/LO.
- Sits between the regfile, the EX/MEM/WB bypass buses and the decode handshake (drives ds_ready_go).

Parameters:
NRD, 2, number of register read ports (rs, rt, ...)
NSRC, 3, number of bypass sources; index 0 = youngest (EX), highest priority
DW, 32, data width
AW, 5, register address width; address 0 is hard-wired zero
LATW, 4, width of the mult/div latency counter

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ds_valid  in  1  decode holds a valid instruction
ds_issue  in  1  decode instruction leaves this cycle (ds_to_es_valid && es_allowin)
flush  in  1  exception/ERET flush; clears the HI/LO scoreboard
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_use  in  NRD  port i operand actually consumed (0 for imm/pc/sa forms)
rf_rdata  in  NRD*DW  register-file read data
byp_valid  in  NSRC  source j writes a GPR this cycle
byp_ready  in  NSRC  source j data is final (0 for a load still in EX)
byp_reg  in  NSRC*AW  source j destination register
byp_data  in  NSRC*DW  source j result
hilo_rd  in  1  decoded instruction is mfhi/mflo
muldiv_issue  in  1  decoded instruction is mult/multu/div/divu
muldiv_lat  in  LATW  cycles until HI/LO valid for the issuing op
op_value  out  NRD*DW  forwarded operand per port
ds_ready_go  out  1  decode may advance
stall_cause  out  2  0 none, 1 data hazard, 2 HI/LO busy, 3 both
hilo_busy  out  1  muldiv counter non-zero

Behaviour:
- Forwarding (combinational), per port i:
  - op_value[i] = byp_data[j] for the lowest j with byp_valid[j] && byp_reg[j]==rd_addr[i] && rd_addr[i]!=0; otherwise rf_rdata[i].
  - Address 0 always yields rf_rdata (regfile returns 0).
- Data hazard: haz_d = OR over i of (rd_use[i] && the winning source j has byp_ready[j]==0).
  - Only the highest-priority match counts; an older ready match must not mask a younger unready one.
- HI/LO counter cnt (LATW bits), reset 0:
  - flush: cnt <= 0. Flush has priority over everything else.
  - else ds_issue && muldiv_issue: cnt <= muldiv_lat.
  - else if cnt != 0: cnt <= cnt - 1.
  - Saturates at 0; never wraps.
- hilo_busy = (cnt != 0). haz_h = hilo_rd && hilo_busy.
- ds_ready_go = ~(haz_d | haz_h). Qualified by ds_valid only through stall_cause: stall_cause = {haz_h, haz_d} & {2{ds_valid}}.
- Issue with muldiv_lat=0 leaves cnt at 0, so no stall is created.
- A second mult/div issuing while busy reloads cnt with its own latency; the latest op wins.
- Asynchronous reset mid-count clears cnt (and the perf counters) immediately. All outputs are combinational from inputs and state, so with all inputs 0: op_value=0, ds_ready_go=1, stall_cause=0, hilo_busy=0.
- Latency: forwarding and stall are zero-cycle. The counter updates on the clock edge after issue, so mfhi decoded in the next cycle observes hilo_busy=1.

Optional Feature:
Macro DS_FWD_PERF_EN.
- Defined: adds outputs perf_data_stall[31:0], perf_hilo_stall[31:0] and perf_fwd_hits[31:0].
  - Each counts cycles with stall_cause[0], stall_cause[1], and ds_issue with any port forwarded, respectively.
  - All three reset to 0 via resetn, wrap modulo 2^32, and are not cleared by flush.
- Not defined: these ports and registers are absent; the remaining behaviour is identical.

Test Plan:
- Priority: rd_addr[0]=5, src0 (reg5, 0x11, ready) and src2 (reg5, 0x33, ready) both valid -> op_value[0]=0x11, ds_ready_go=1.
- Load-use: src0 valid, reg 8, byp_ready[0]=0; port1 addr 8, rd_use[1]=1, ds_valid=1 -> ds_ready_go=0, stall_cause=1. Next cycle src1 (reg8, 0xCAFE, ready) -> op_value[1]=0xCAFE, go=1.
- Masking and zero register:
  - Unready src0 on reg 8 plus ready src1 on reg 8 -> stall.
  - rd_addr=0 with src0 on reg 0 (0xFFFF) -> op_value=rf_rdata, no stall.
  - rd_use=0 on an unready match -> no stall.
- HI/LO: issue mult with lat=3 -> hilo_busy high for 3 cycles; mfhi decoded on each of those cycles -> stall_cause=2; 4th cycle -> go=1.
- Reload and flush: issue lat=5, after 2 cycles issue lat=2 -> busy for exactly 2 more cycles. Separately, flush while cnt=4 -> cnt=0 the next cycle.
- Reset: assert resetn=0 asynchronously mid-count (cnt=3) -> hilo_busy=0 before the next clk edge; perf counters (if DS_FWD_PERF_EN) read 0.

Source files
------------

// File: rtl/ds_fwd_interlock.sv
// Decode-stage operand forwarding and interlock: youngest-match bypass per read port,
// data-hazard and HI/LO-busy stalls. Optional perf counters under DS_FWD_PERF_EN.
module ds_fwd_interlock #(
    parameter int unsigned NRD  = 2,
    parameter int unsigned NSRC = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned LATW = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ds_valid,
    input  logic                ds_issue,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD-1:0]      rd_use,
    input  logic [NRD*DW-1:0]   rf_rdata,
    input  logic [NSRC-1:0]     byp_valid,
    input  logic [NSRC-1:0]     byp_ready,
    input  logic [NSRC*AW-1:0]  byp_reg,
    input  logic [NSRC*DW-1:0]  byp_data,
    input  logic                hilo_rd,
    input  logic                muldiv_issue,
    input  logic [LATW-1:0]     muldiv_lat,
    output logic [NRD*DW-1:0]   op_value,
    output logic                ds_ready_go,
    output logic [1:0]          stall_cause,
    output logic                hilo_busy
`ifdef DS_FWD_PERF_EN
    ,
    output logic [31:0]         perf_data_stall,
    output logic [31:0]         perf_hilo_stall,
    output logic [31:0]         perf_fwd_hits
`endif
);

    logic [NRD-1:0]  port_hit;
    logic [NRD-1:0]  port_unready;
    logic            haz_d;
    logic            haz_h;
    logic [LATW-1:0] cnt_q;
    logic [LATW-1:0] cnt_d;

    // Scan oldest to youngest so the lowest-index match overwrites older ones; its ready
    // bit alone decides the hazard, so an older ready copy cannot hide a younger load.
    always_comb begin
        op_value     = rf_rdata;
        port_hit     = '0;
        port_unready = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            for (int j = int'(NSRC) - 1; j >= 0; j--) begin
                if (byp_valid[j] && (byp_reg[j*AW +: AW] == rd_addr[i*AW +: AW]) &&
                    (rd_addr[i*AW +: AW] != '0)) begin
                    op_value[i*DW +: DW] = byp_data[j*DW +: DW];
                    port_hit[i]          = 1'b1;
                    port_unready[i]      = ~byp_ready[j];
                end
            end
        end
    end

    assign haz_d       = |(port_unready & rd_use);
    assign hilo_busy   = (cnt_q != '0);
    assign haz_h       = hilo_rd & hilo_busy;
    assign ds_ready_go = ~(haz_d | haz_h);
    assign stall_cause = {haz_h, haz_d} & {2{ds_valid}};

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (ds_issue && muldiv_issue) begin
            cnt_d = muldiv_lat;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef DS_FWD_PERF_EN
    logic [31:0] perf_data_q;
    logic [31:0] perf_hilo_q;
    logic [31:0] perf_fwd_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_data_q <= '0;
            perf_hilo_q <= '0;
            perf_fwd_q  <= '0;
        end else begin
            if (stall_cause[0]) begin
                perf_data_q <= perf_data_q + 32'd1;
            end
            if (stall_cause[1]) begin
                perf_hilo_q <= perf_hilo_q + 32'd1;
            end
            if (ds_issue && (|port_hit)) begin
                perf_fwd_q <= perf_fwd_q + 32'd1;
            end
        end
    end

    assign perf_data_stall = perf_data_q;
    assign perf_hilo_stall = perf_hilo_q;
    assign perf_fwd_hits   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_ds_fwd_interlock.sv
// Bench for ds_fwd_interlock: table of combinational forwarding vectors plus
// hand-written HI/LO counter sequences, checked through an expected-value queue.
module tb_ds_fwd_interlock;

    localparam int unsigned NRD  = 2;
    localparam int unsigned NSRC = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned LATW = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic                ds_valid;
    logic                ds_issue;
    logic                flush;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_use;
    logic [NRD*DW-1:0]   rf_rdata;
    logic [NSRC-1:0]     byp_valid;
    logic [NSRC-1:0]     byp_ready;
    logic [NSRC*AW-1:0]  byp_reg;
    logic [NSRC*DW-1:0]  byp_data;
    logic                hilo_rd;
    logic                muldiv_issue;
    logic [LATW-1:0]     muldiv_lat;
    logic [NRD*DW-1:0]   op_value;
    logic                ds_ready_go;
    logic [1:0]          stall_cause;
    logic                hilo_busy;
`ifdef DS_FWD_PERF_EN
    logic [31:0]         perf_data_stall;
    logic [31:0]         perf_hilo_stall;
    logic [31:0]         perf_fwd_hits;
`endif

    ds_fwd_interlock #(
        .NRD (NRD),
        .NSRC(NSRC),
        .DW  (DW),
        .AW  (AW),
        .LATW(LATW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ds_valid    (ds_valid),
        .ds_issue    (ds_issue),
        .flush       (flush),
        .rd_addr     (rd_addr),
        .rd_use      (rd_use),
        .rf_rdata    (rf_rdata),
        .byp_valid   (byp_valid),
        .byp_ready   (byp_ready),
        .byp_reg     (byp_reg),
        .byp_data    (byp_data),
        .hilo_rd     (hilo_rd),
        .muldiv_issue(muldiv_issue),
        .muldiv_lat  (muldiv_lat),
        .op_value    (op_value),
        .ds_ready_go (ds_ready_go),
        .stall_cause (stall_cause),
        .hilo_busy   (hilo_busy)
`ifdef DS_FWD_PERF_EN
        ,
        .perf_data_stall(perf_data_stall),
        .perf_hilo_stall(perf_hilo_stall),
        .perf_fwd_hits  (perf_fwd_hits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] op;
        logic        go;
        logic [1:0]  cause;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [1:0]  use_m;
        logic [63:0] rf;
        logic [2:0]  bv;
        logic [2:0]  br;
        logic [14:0] breg;
        logic [95:0] bdata;
        logic        dv;
        logic [63:0] e_op;
        logic        e_go;
        logic [1:0]  e_cause;
    } vec_t;

    exp_t sb[$];
    vec_t vt[10];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [31:0] RF0 = 32'h0000_A0A0;
    localparam logic [31:0] RF1 = 32'h0000_B1B1;

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a0,
                                input logic [1:0] u, input logic [2:0] bv,
                                input logic [2:0] br, input logic [14:0] breg,
                                input logic [95:0] bdata, input logic dv,
                                input logic [63:0] eop, input logic ego,
                                input logic [1:0] ecause);
        vec_t v;
        v.addr    = {a1, a0};
        v.use_m   = u;
        v.rf      = {RF1, RF0};
        v.bv      = bv;
        v.br      = br;
        v.breg    = breg;
        v.bdata   = bdata;
        v.dv      = dv;
        v.e_op    = eop;
        v.e_go    = ego;
        v.e_cause = ecause;
        return v;
    endfunction

    task automatic expect_out(input logic [63:0] op, input logic go, input logic [1:0] cause,
                              input logic busy);
        exp_t e;
        e.op    = op;
        e.go    = go;
        e.cause = cause;
        e.busy  = busy;
        sb.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (op_value !== e.op || ds_ready_go !== e.go || stall_cause !== e.cause ||
            hilo_busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s: got op=%h go=%b cause=%0d busy=%b, want op=%h go=%b cause=%0d busy=%b",
                     name, op_value, ds_ready_go, stall_cause, hilo_busy,
                     e.op, e.go, e.cause, e.busy);
        end
    endtask

    task automatic clear_inputs();
        ds_valid     = 1'b0;
        ds_issue     = 1'b0;
        flush        = 1'b0;
        rd_addr      = '0;
        rd_use       = '0;
        rf_rdata     = '0;
        byp_valid    = '0;
        byp_ready    = '0;
        byp_reg      = '0;
        byp_data     = '0;
        hilo_rd      = 1'b0;
        muldiv_issue = 1'b0;
        muldiv_lat   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [LATW-1:0] lat);
        ds_valid     = 1'b1;
        ds_issue     = 1'b1;
        muldiv_issue = 1'b1;
        muldiv_lat   = lat;
    endtask

    task automatic end_issue();
        ds_issue     = 1'b0;
        muldiv_issue = 1'b0;
        muldiv_lat   = '0;
    endtask

`ifdef DS_FWD_PERF_EN
    task automatic check_perf_zero();
        n_vec++;
        if (perf_data_stall !== 32'd0 || perf_hilo_stall !== 32'd0 || perf_fwd_hits !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_reset: got data=%0d hilo=%0d fwd=%0d, want 0 0 0",
                     perf_data_stall, perf_hilo_stall, perf_fwd_hits);
        end
    endtask
`endif

    initial begin
        // addr1, addr0, use, bv, br, breg{r2,r1,r0}, bdata{d2,d1,d0}, dv, exp op, go, cause
        vt[0] = mk(5'd7, 5'd5, 2'b11, 3'b101, 3'b101, {5'd5, 5'd0, 5'd5},
                   {32'h33, 32'h0, 32'h11}, 1'b1, {RF1, 32'h11}, 1'b1, 2'd0);
        vt[1] = mk(5'd8, 5'd3, 2'b10, 3'b001, 3'b000, {5'd0, 5'd0, 5'd8},
                   {32'h0, 32'h0, 32'hDEAD}, 1'b1, {32'hDEAD, RF0}, 1'b0, 2'd1);
        vt[2] = mk(5'd8, 5'd3, 2'b10, 3'b010, 3'b010, {5'd0, 5'd8, 5'd0},
                   {32'h0, 32'hCAFE, 32'h0}, 1'b1, {32'hCAFE, RF0}, 1'b1, 2'd0);
        vt[3] = mk(5'd8, 5'd3, 2'b10, 3'b011, 3'b010, {5'd0, 5'd8, 5'd8},
                   {32'h0, 32'h2, 32'h1}, 1'b1, {32'h1, RF0}, 1'b0, 2'd1);
        vt[4] = mk(5'd0, 5'd0, 2'b11, 3'b001, 3'b000, {5'd0, 5'd0, 5'd0},
                   {32'h0, 32'h0, 32'hFFFF}, 1'b1, {RF1, RF0}, 1'b1, 2'd0);
        vt[5] = mk(5'd2, 5'd9, 2'b00, 3'b001, 3'b000, {5'd0, 5'd0, 5'd9},
                   {32'h0, 32'h0, 32'h99}, 1'b1, {RF1, 32'h99}, 1'b1, 2'd0);
        vt[6] = mk(5'd8, 5'd3, 2'b10, 3'b001, 3'b000, {5'd0, 5'd0, 5'd8},
                   {32'h0, 32'h0, 32'hDEAD}, 1'b0, {32'hDEAD, RF0}, 1'b0, 2'd0);
        vt[7] = mk(5'd1, 5'd4, 2'b01, 3'b110, 3'b100, {5'd4, 5'd6, 5'd0},
                   {32'h44, 32'h66, 32'h0}, 1'b1, {RF1, 32'h44}, 1'b1, 2'd0);
        vt[8] = mk(5'd11, 5'd10, 2'b11, 3'b110, 3'b100, {5'd11, 5'd10, 5'd0},
                   {32'h2B, 32'h2A, 32'h0}, 1'b1, {32'h2B, 32'h2A}, 1'b0, 2'd1);
        vt[9] = mk(5'd12, 5'd12, 2'b11, 3'b111, 3'b111, {5'd12, 5'd12, 5'd12},
                   {32'hC2, 32'hC1, 32'hC0}, 1'b1, {32'hC0, 32'hC0}, 1'b1, 2'd0);

        clear_inputs();
        resetn = 1'b0;
        #2;
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        check_out("reset_idle");
        #10 resetn = 1'b1;
        tick();

        for (int k = 0; k < 10; k++) begin
            rd_addr   = vt[k].addr;
            rd_use    = vt[k].use_m;
            rf_rdata  = vt[k].rf;
            byp_valid = vt[k].bv;
            byp_ready = vt[k].br;
            byp_reg   = vt[k].breg;
            byp_data  = vt[k].bdata;
            ds_valid  = vt[k].dv;
            expect_out(vt[k].e_op, vt[k].e_go, vt[k].e_cause, 1'b0);
            #2;
            check_out($sformatf("vec%0d", k));
            tick();
        end
        clear_inputs();

        // mult lat=3, then mfhi stalls for exactly 3 cycles
        issue(4'd3);
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("mul_issue");
        tick();
        end_issue();
        hilo_rd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            expect_out(64'd0, 1'b0, 2'd2, 1'b1);
            #2 check_out($sformatf("mfhi_stall%0d", c));
            tick();
        end
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("mfhi_go");
        hilo_rd = 1'b0;
        tick();

        // reload: lat=5, then lat=2 two cycles later wins
        issue(4'd5);
        tick();
        end_issue();
        expect_out(64'd0, 1'b1, 2'd0, 1'b1);
        #2 check_out("reload_cnt5");
        tick();
        issue(4'd2);
        expect_out(64'd0, 1'b1, 2'd0, 1'b1);
        #2 check_out("reload_cnt4");
        tick();
        end_issue();
        hilo_rd = 1'b1;
        for (int c = 0; c < 2; c++) begin
            expect_out(64'd0, 1'b0, 2'd2, 1'b1);
            #2 check_out($sformatf("reload_busy%0d", c));
            tick();
        end
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("reload_done");
        hilo_rd = 1'b0;

        // lat=0 issue creates no stall
        issue(4'd0);
        tick();
        end_issue();
        hilo_rd = 1'b1;
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("lat_zero");
        hilo_rd = 1'b0;

        // flush while cnt=4
        issue(4'd4);
        tick();
        end_issue();
        expect_out(64'd0, 1'b1, 2'd0, 1'b1);
        #2 check_out("flush_pre");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("flush_post");

        // flush beats a simultaneous issue
        issue(4'd6);
        flush = 1'b1;
        tick();
        end_issue();
        flush = 1'b0;
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("flush_vs_issue");

        // async reset mid-count (cnt=3) clears before the next edge
        issue(4'd5);
        tick();
        end_issue();
        hilo_rd = 1'b1;
        tick();
        tick();
        expect_out(64'd0, 1'b0, 2'd2, 1'b1);
        #2 check_out("rst_pre_cnt3");
        #1 resetn = 1'b0;
        expect_out(64'd0, 1'b1, 2'd0, 1'b0);
        #2 check_out("rst_async");
`ifdef DS_FWD_PERF_EN
        check_perf_zero();
`endif
        #2 resetn = 1'b1;
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
